exec_alu_seq: RTL and testbench
===============================

EXEC_ALU_SEQ -- requirements
Module: exec_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports in_valid input 1 and in_ready output 1: request handshake.
REQ-005 SHALL have ports pc, alu_a, alu_b, jmp_off, each input WIDTH: request operands.
REQ-006 SHALL have ports alu_op input 3, inv_a input 1, inv_b input 1, cin input 1, jump input 1: request controls.
REQ-007 SHALL have shared-ALU drive ports, all outputs: sh_in_a WIDTH, sh_in_b WIDTH, sh_oper 3, sh_inv_a 1, sh_inv_b 1, sh_cin 1, sh_sign 1.
REQ-008 SHALL have shared-ALU return ports, all inputs: sh_out WIDTH, sh_zero 1, sh_ofl 1.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1: result handshake.
REQ-010 SHALL have result ports, all outputs: alu_out WIDTH, zf 1, of 1, next_pc WIDTH.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL sequence one shared ALU for both the data operation and the PC+offset target add, replacing a dedicated target adder.
REQ-013 SHALL implement the FSM states IDLE, OPR, TGT and HOLD.
REQ-014 SHALL drive in_ready = (state==IDLE) | (state==HOLD & out_ready).
REQ-015 SHALL latch all request inputs on in_valid & in_ready and enter OPR.
REQ-016 In OPR, SHALL drive the shared ALU from the latched alu_a, alu_b, alu_op, inv_a, inv_b and cin with sh_sign=1, and capture sh_out, sh_zero and sh_ofl into alu_out, zf and of at the cycle end.
REQ-017 In TGT, SHALL drive sh_in_a=pc, sh_in_b=jmp_off, sh_oper=3'b000, inv_a=inv_b=cin=0 and sh_sign=0.
REQ-018 At the end of TGT, SHALL capture next_pc = jump ? sh_out : pc.
REQ-019 OPR SHALL go to TGT; TGT SHALL go to HOLD.
REQ-020 In HOLD, SHALL hold out_valid=1 with stable results until out_ready is seen.
REQ-021 On out_ready in HOLD, SHALL go to OPR if a new request is accepted in the same cycle, else to IDLE.
REQ-022 Latency: with accept at edge E, out_valid SHALL assert after edge E+2.
REQ-023 Sustained throughput SHALL be one result per 3 cycles.
REQ-024 In IDLE and HOLD, all sh_* outputs SHALL be driven to 0.
REQ-025 Result registers SHALL change only on a capture and otherwise hold their values.
REQ-026 Offset arithmetic SHALL be modulo 2^WIDTH; the target add SHALL wrap silently, with sh_ofl ignored in TGT.
REQ-027 in_valid while busy and not accepting SHALL be ignored; the requester holds it.

Reset
REQ-028 On rst, the FSM SHALL go to IDLE asynchronously and any in-flight request SHALL be dropped.
REQ-029 On rst, out_valid, busy, alu_out, zf, of, next_pc and all sh_* outputs SHALL be 0, and in_ready SHALL be 1 once IDLE.

Configuration
REQ-030 The macro EXEC_JMP_SKIP_EN SHALL control the TGT phase.
REQ-031 With EXEC_JMP_SKIP_EN defined, a request with jump=0 SHALL go from OPR directly to HOLD with next_pc=pc, giving latency E+1.
REQ-032 Without EXEC_JMP_SKIP_EN, every request SHALL pass through TGT.

Structure
REQ-033 Package exec_ctrl_pkg SHALL hold the state enum, the ALU op constants (ADD=3'b000) and the default WIDTH.
REQ-034 The design SHALL be a single module with no sub-module; operand muxing SHALL be inline and keyed on state.

Verification
REQ-035 Stimulus: alu_a=0x0005, alu_b=0x0003, alu_op=ADD, pc=0x0100, jmp_off=0x0010, jump=1. Response: alu_out=0x0008, zf=0, next_pc=0x0110, out_valid 2 cycles after accept.
REQ-036 Stimulus: alu_a=0x7FFF, alu_b=0x0001, ADD. Response: alu_out=0x8000, of=1. Stimulus: alu_a=0x0001, alu_b=0x0001, inv_b=1, cin=1. Response: alu_out=0x0000, zf=1.
REQ-037 Stimulus: jump=0, pc=0x0200. Response: next_pc=0x0200 after 2 cycles without the macro, after 1 cycle with it.
REQ-038 Stimulus: pc=0xFFF0, jmp_off=0x0020, jump=1. Response: next_pc=0x0010 (wrap).
REQ-039 Stimulus: out_ready held 0 for 5 cycles, then two back-to-back requests. Response: results stable while held; second request accepted on the out_ready cycle; no bubble beyond 3-cycle spacing.
REQ-040 Stimulus: rst asserted during TGT. Response: immediate IDLE, out_valid=0, all outputs 0, no result emitted after reset release.

Source files
------------

// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for exec_alu_seq: FSM state encoding, ALU op codes, default width.
package exec_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned OP_W          = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_AND = 3'b001;
    localparam logic [OP_W-1:0] OP_OR  = 3'b010;
    localparam logic [OP_W-1:0] OP_XOR = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPR  = 2'd1,
        TGT  = 2'd2,
        HOLD = 2'd3
    } state_e;

endpackage

// File: rtl/exec_alu_seq.sv
// exec_alu_seq: sequences one shared ALU for the data op (OPR) and the
// PC+offset branch target add (TGT), then holds the result until consumed.
// Optional: define EXEC_JMP_SKIP_EN to skip TGT for requests with jump=0.
module exec_alu_seq
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] jmp_off,
    input  logic [OP_W-1:0]  alu_op,
    input  logic             inv_a,
    input  logic             inv_b,
    input  logic             cin,
    input  logic             jump,
    output logic [WIDTH-1:0] sh_in_a,
    output logic [WIDTH-1:0] sh_in_b,
    output logic [OP_W-1:0]  sh_oper,
    output logic             sh_inv_a,
    output logic             sh_inv_b,
    output logic             sh_cin,
    output logic             sh_sign,
    input  logic [WIDTH-1:0] sh_out,
    input  logic             sh_zero,
    input  logic             sh_ofl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zf,
    output logic             of,
    output logic [WIDTH-1:0] next_pc,
    output logic             busy
);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  pc_q, pc_d, a_q, a_d, b_q, b_d, off_q, off_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              inv_a_q, inv_a_d, inv_b_q, inv_b_d, cin_q, cin_d, jump_q, jump_d;
    logic [WIDTH-1:0]  alu_out_q, alu_out_d, next_pc_q, next_pc_d;
    logic              zf_q, zf_d, of_q, of_d;
    logic              out_valid_q, out_valid_d, busy_q, busy_d;
    logic [WIDTH-1:0]  sh_in_a_q, sh_in_a_d, sh_in_b_q, sh_in_b_d;
    logic [OP_W-1:0]   sh_oper_q, sh_oper_d;
    logic              sh_inv_a_q, sh_inv_a_d, sh_inv_b_q, sh_inv_b_d;
    logic              sh_cin_q, sh_cin_d, sh_sign_q, sh_sign_d;
    logic              accept_c;

    // Ready in IDLE, or in HOLD when the current result is being consumed.
    assign in_ready = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
    assign accept_c = in_valid & in_ready;

    // Next state, request latch and result capture.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        a_d       = a_q;
        b_d       = b_q;
        off_d     = off_q;
        op_d      = op_q;
        inv_a_d   = inv_a_q;
        inv_b_d   = inv_b_q;
        cin_d     = cin_q;
        jump_d    = jump_q;
        alu_out_d = alu_out_q;
        zf_d      = zf_q;
        of_d      = of_q;
        next_pc_d = next_pc_q;

        if (accept_c) begin
            pc_d    = pc;
            a_d     = alu_a;
            b_d     = alu_b;
            off_d   = jmp_off;
            op_d    = alu_op;
            inv_a_d = inv_a;
            inv_b_d = inv_b;
            cin_d   = cin;
            jump_d  = jump;
        end

        case (state_q)
            IDLE: if (accept_c) state_d = OPR;
            OPR: begin
                alu_out_d = sh_out;
                zf_d      = sh_zero;
                of_d      = sh_ofl;
`ifdef EXEC_JMP_SKIP_EN
                if (!jump_q) begin
                    next_pc_d = pc_q;
                    state_d   = HOLD;
                end else begin
                    state_d   = TGT;
                end
`else
                state_d = TGT;
`endif
            end
            TGT: begin
                // Target add wraps modulo 2^WIDTH; sh_ofl is irrelevant here.
                next_pc_d = jump_q ? sh_out : pc_q;
                state_d   = HOLD;
            end
            HOLD: if (out_ready) state_d = accept_c ? OPR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shared-ALU drive and status, computed for the state being entered so they are registered.
    always_comb begin
        sh_in_a_d  = '0;
        sh_in_b_d  = '0;
        sh_oper_d  = '0;
        sh_inv_a_d = 1'b0;
        sh_inv_b_d = 1'b0;
        sh_cin_d   = 1'b0;
        sh_sign_d  = 1'b0;
        case (state_d)
            OPR: begin
                sh_in_a_d  = a_d;
                sh_in_b_d  = b_d;
                sh_oper_d  = op_d;
                sh_inv_a_d = inv_a_d;
                sh_inv_b_d = inv_b_d;
                sh_cin_d   = cin_d;
                sh_sign_d  = 1'b1;
            end
            TGT: begin
                sh_in_a_d = pc_d;
                sh_in_b_d = off_d;
                sh_oper_d = OP_ADD;
            end
            default: ;
        endcase
        out_valid_d = (state_d == HOLD);
        busy_d      = (state_d != IDLE);
    end

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            off_q       <= '0;
            op_q        <= '0;
            inv_a_q     <= 1'b0;
            inv_b_q     <= 1'b0;
            cin_q       <= 1'b0;
            jump_q      <= 1'b0;
            alu_out_q   <= '0;
            zf_q        <= 1'b0;
            of_q        <= 1'b0;
            next_pc_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sh_in_a_q   <= '0;
            sh_in_b_q   <= '0;
            sh_oper_q   <= '0;
            sh_inv_a_q  <= 1'b0;
            sh_inv_b_q  <= 1'b0;
            sh_cin_q    <= 1'b0;
            sh_sign_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            off_q       <= off_d;
            op_q        <= op_d;
            inv_a_q     <= inv_a_d;
            inv_b_q     <= inv_b_d;
            cin_q       <= cin_d;
            jump_q      <= jump_d;
            alu_out_q   <= alu_out_d;
            zf_q        <= zf_d;
            of_q        <= of_d;
            next_pc_q   <= next_pc_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            sh_in_a_q   <= sh_in_a_d;
            sh_in_b_q   <= sh_in_b_d;
            sh_oper_q   <= sh_oper_d;
            sh_inv_a_q  <= sh_inv_a_d;
            sh_inv_b_q  <= sh_inv_b_d;
            sh_cin_q    <= sh_cin_d;
            sh_sign_q   <= sh_sign_d;
        end
    end

    assign sh_in_a   = sh_in_a_q;
    assign sh_in_b   = sh_in_b_q;
    assign sh_oper   = sh_oper_q;
    assign sh_inv_a  = sh_inv_a_q;
    assign sh_inv_b  = sh_inv_b_q;
    assign sh_cin    = sh_cin_q;
    assign sh_sign   = sh_sign_q;
    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;
    assign zf        = zf_q;
    assign of        = of_q;
    assign next_pc   = next_pc_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_exec_alu_seq.sv
// Directed testbench for exec_alu_seq with a behavioural shared ALU attached.
module tb_exec_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] pc = '0, alu_a = '0, alu_b = '0, jmp_off = '0;
    logic [2:0]  alu_op = '0;
    logic        inv_a = 1'b0, inv_b = 1'b0, cin = 1'b0, jump = 1'b0;
    logic [15:0] sh_in_a, sh_in_b;
    logic [2:0]  sh_oper;
    logic        sh_inv_a, sh_inv_b, sh_cin, sh_sign;
    logic [15:0] sh_out;
    logic        sh_zero, sh_ofl;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] alu_out, next_pc;
    logic        zf, of, busy;

    int n_cmp = 0;
    int n_bad = 0;

    exec_alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .alu_a(alu_a), .alu_b(alu_b), .jmp_off(jmp_off),
        .alu_op(alu_op), .inv_a(inv_a), .inv_b(inv_b), .cin(cin), .jump(jump),
        .sh_in_a(sh_in_a), .sh_in_b(sh_in_b), .sh_oper(sh_oper),
        .sh_inv_a(sh_inv_a), .sh_inv_b(sh_inv_b), .sh_cin(sh_cin), .sh_sign(sh_sign),
        .sh_out(sh_out), .sh_zero(sh_zero), .sh_ofl(sh_ofl),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .zf(zf), .of(of), .next_pc(next_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural shared ALU: ADD/AND/OR/XOR on optionally inverted operands.
    logic [15:0] m_a, m_b;
    logic [16:0] m_sum;
    always_comb begin
        m_a   = sh_inv_a ? ~sh_in_a : sh_in_a;
        m_b   = sh_inv_b ? ~sh_in_b : sh_in_b;
        m_sum = {1'b0, m_a} + {1'b0, m_b} + 17'(sh_cin);
        case (sh_oper)
            3'b000:  sh_out = m_sum[15:0];
            3'b001:  sh_out = m_a & m_b;
            3'b010:  sh_out = m_a | m_b;
            default: sh_out = m_a ^ m_b;
        endcase
        sh_zero = (sh_out == 16'h0000);
        sh_ofl  = sh_sign ? ((m_a[15] == m_b[15]) && (sh_out[15] != m_a[15])) : m_sum[16];
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Present a request and wait (bounded) for it to be accepted; returns 1 ns after the accept edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ia, input logic ib,
                        input logic ci, input logic [15:0] p, input logic [15:0] off, input logic j);
        logic acc;
        alu_a = a; alu_b = b; alu_op = 3'b000; inv_a = ia; inv_b = ib; cin = ci;
        pc = p; jmp_off = off; jump = j; in_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin
            #1;
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (!acc) begin n_bad++; $display("FAIL send_accept: got no accept within 20 cycles, required accept"); end
    endtask

    task automatic drain;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(); step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if ({alu_out, next_pc, zf, of} !== 34'h0) begin n_bad++; $display("FAIL reset_results: got %h want 0", {alu_out, next_pc, zf, of}); end
        n_cmp++; if ({sh_in_a, sh_in_b, sh_oper, sh_inv_a, sh_inv_b, sh_cin, sh_sign} !== 39'h0) begin n_bad++; $display("FAIL reset_sh: got %h want 0", {sh_in_a, sh_in_b, sh_oper, sh_inv_a, sh_inv_b, sh_cin, sh_sign}); end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_add_jump;
        send(16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0010, 1'b1);
        // OPR
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_opr_valid: got %b want 0", out_valid); end
        n_cmp++; if ({sh_in_a, sh_in_b, sh_sign} !== {16'h0005, 16'h0003, 1'b1}) begin n_bad++; $display("FAIL add_opr_sh: got %h want %h", {sh_in_a, sh_in_b, sh_sign}, {16'h0005, 16'h0003, 1'b1}); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL add_busy: got %b want 1", busy); end
        step();
        // TGT
        n_cmp++; if ({sh_in_a, sh_in_b, sh_oper, sh_sign} !== {16'h0100, 16'h0010, 3'b000, 1'b0}) begin n_bad++; $display("FAIL add_tgt_sh: got %h want %h", {sh_in_a, sh_in_b, sh_oper, sh_sign}, {16'h0100, 16'h0010, 3'b000, 1'b0}); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_tgt_valid: got %b want 0", out_valid); end
        step();
        // HOLD
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_hold_valid: got %b want 1", out_valid); end
        n_cmp++; if (alu_out !== 16'h0008) begin n_bad++; $display("FAIL add_alu_out: got %h want 0008", alu_out); end
        n_cmp++; if (zf !== 1'b0) begin n_bad++; $display("FAIL add_zf: got %b want 0", zf); end
        n_cmp++; if (next_pc !== 16'h0110) begin n_bad++; $display("FAIL add_next_pc: got %h want 0110", next_pc); end
        n_cmp++; if ({sh_in_a, sh_in_b, sh_sign} !== 33'h0) begin n_bad++; $display("FAIL add_hold_sh: got %h want 0", {sh_in_a, sh_in_b, sh_sign}); end
        drain();
        n_cmp++; if ({out_valid, busy, in_ready} !== 3'b001) begin n_bad++; $display("FAIL add_idle: got %b want 001", {out_valid, busy, in_ready}); end
    endtask

    task automatic test_overflow;
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0003, 1'b1);
        step(); step();
        n_cmp++; if ({alu_out, of, zf} !== {16'h8000, 1'b1, 1'b0}) begin n_bad++; $display("FAIL ovf_result: got %h want %h", {alu_out, of, zf}, {16'h8000, 1'b1, 1'b0}); end
        n_cmp++; if (next_pc !== 16'h0023) begin n_bad++; $display("FAIL ovf_next_pc: got %h want 0023", next_pc); end
        drain();
    endtask

    task automatic test_sub_zero;
        send(16'h0001, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0040, 16'h0004, 1'b1);
        n_cmp++; if ({sh_inv_b, sh_cin, sh_inv_a} !== 3'b110) begin n_bad++; $display("FAIL sub_ctrl: got %b want 110", {sh_inv_b, sh_cin, sh_inv_a}); end
        step(); step();
        n_cmp++; if ({alu_out, zf, of} !== {16'h0000, 1'b1, 1'b0}) begin n_bad++; $display("FAIL sub_result: got %h want %h", {alu_out, zf, of}, {16'h0000, 1'b1, 1'b0}); end
        drain();
    endtask

    task automatic test_no_jump;
        send(16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0200, 16'h0040, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL nojmp_opr_valid: got %b want 0", out_valid); end
        step();
`ifdef EXEC_JMP_SKIP_EN
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL nojmp_skip_valid: got %b want 1", out_valid); end
        n_cmp++; if (next_pc !== 16'h0200) begin n_bad++; $display("FAIL nojmp_next_pc: got %h want 0200", next_pc); end
`else
        n_cmp++; if ({out_valid, sh_in_a} !== {1'b0, 16'h0200}) begin n_bad++; $display("FAIL nojmp_tgt: got %h want %h", {out_valid, sh_in_a}, {1'b0, 16'h0200}); end
        step();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL nojmp_valid: got %b want 1", out_valid); end
        n_cmp++; if (next_pc !== 16'h0200) begin n_bad++; $display("FAIL nojmp_next_pc: got %h want 0200", next_pc); end
`endif
        n_cmp++; if (alu_out !== 16'h0004) begin n_bad++; $display("FAIL nojmp_alu_out: got %h want 0004", alu_out); end
        drain();
    endtask

    task automatic test_wrap;
        send(16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0, 16'hFFF0, 16'h0020, 1'b1);
        step(); step();
        n_cmp++; if (next_pc !== 16'h0010) begin n_bad++; $display("FAIL wrap_next_pc: got %h want 0010", next_pc); end
        n_cmp++; if ({alu_out, of} !== {16'h0030, 1'b0}) begin n_bad++; $display("FAIL wrap_alu: got %h want %h", {alu_out, of}, {16'h0030, 1'b0}); end
        drain();
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        send(16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0001, 1'b1);
        step(); step();
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({out_valid, in_ready, busy, alu_out, next_pc} !== {3'b101, 16'h0005, 16'h0011}) begin n_bad++; $display("FAIL b2b_hold%0d: got %h want %h", i, {out_valid, in_ready, busy, alu_out, next_pc}, {3'b101, 16'h0005, 16'h0011}); end
            step();
        end
        // Second request presented in the same cycle the first result is consumed.
        alu_a = 16'h0100; alu_b = 16'h0200; pc = 16'h0300; jmp_off = 16'h0010; jump = 1'b1;
        inv_a = 1'b0; inv_b = 1'b0; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_on_consume: got %b want 1", in_ready); end
        step();
        // Third request held by the requester while the second is in flight.
        alu_a = 16'h0001; alu_b = 16'hFFFF; pc = 16'h0077; jmp_off = 16'h0000;
        n_cmp++; if ({in_ready, out_valid, sh_in_a} !== {2'b00, 16'h0100}) begin n_bad++; $display("FAIL b2b_r2_opr: got %h want %h", {in_ready, out_valid, sh_in_a}, {2'b00, 16'h0100}); end
        step();
        n_cmp++; if ({in_ready, out_valid, alu_out} !== {2'b00, 16'h0300}) begin n_bad++; $display("FAIL b2b_r2_tgt: got %h want %h", {in_ready, out_valid, alu_out}, {2'b00, 16'h0300}); end
        step();
        n_cmp++; if ({out_valid, in_ready, alu_out, next_pc} !== {2'b11, 16'h0300, 16'h0310}) begin n_bad++; $display("FAIL b2b_r2_hold: got %h want %h", {out_valid, in_ready, alu_out, next_pc}, {2'b11, 16'h0300, 16'h0310}); end
        step();
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, busy, sh_in_a, sh_in_b} !== {2'b01, 16'h0001, 16'hFFFF}) begin n_bad++; $display("FAIL b2b_r3_opr: got %h want %h", {out_valid, busy, sh_in_a, sh_in_b}, {2'b01, 16'h0001, 16'hFFFF}); end
        step(); step();
        n_cmp++; if ({out_valid, alu_out, zf, next_pc} !== {1'b1, 16'h0000, 1'b1, 16'h0077}) begin n_bad++; $display("FAIL b2b_r3_hold: got %h want %h", {out_valid, alu_out, zf, next_pc}, {1'b1, 16'h0000, 1'b1, 16'h0077}); end
        step();
        out_ready = 1'b0;
        n_cmp++; if ({out_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL b2b_idle: got %b want 00", {out_valid, busy}); end
    endtask

    task automatic test_reset_tgt;
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0500, 16'h0005, 1'b1);
        step();
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if ({out_valid, busy, in_ready} !== 3'b001) begin n_bad++; $display("FAIL rst_tgt_ctrl: got %b want 001", {out_valid, busy, in_ready}); end
        n_cmp++; if ({alu_out, next_pc, zf, of} !== 34'h0) begin n_bad++; $display("FAIL rst_tgt_results: got %h want 0", {alu_out, next_pc, zf, of}); end
        n_cmp++; if ({sh_in_a, sh_in_b, sh_oper, sh_sign} !== 36'h0) begin n_bad++; $display("FAIL rst_tgt_sh: got %h want 0", {sh_in_a, sh_in_b, sh_oper, sh_sign}); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if ({out_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL rst_tgt_post%0d: got %b want 00", i, {out_valid, busy}); end
        end
    endtask

    initial begin
        test_reset();
        test_add_jump();
        test_overflow();
        test_sub_zero();
        test_no_jump();
        test_wrap();
        test_back_to_back();
        test_reset_tgt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
